// File: rtl/enc_tx_sched.sv
// Transmit scheduler for the 8B/10B encoder: training burst, framed packets,
// K28.5 idle fill and periodic K28.0 clock-compensation skips, one character per clock.
module enc_tx_sched #(
    parameter int TRAIN_LEN   = 16,
    parameter int CC_INTERVAL = 256,
    parameter int SKIP_LEN    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       train_req,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       link_up,
    output logic       underrun
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K28_0 = 8'h1C;

    localparam int CNT_MAX = (TRAIN_LEN > SKIP_LEN) ? TRAIN_LEN : SKIP_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int CC_W    = $clog2(CC_INTERVAL);

    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST  = CNT_W'(SKIP_LEN - 1);
    localparam logic [CC_W-1:0]  CC_LAST    = CC_W'(CC_INTERVAL - 1);

    typedef enum logic [2:0] {
        ST_TRAIN,
        ST_IDLE,
        ST_SKIP,
        ST_SOP,
        ST_DATA,
        ST_EOP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] wordCnt_q;
    logic [CC_W-1:0]  ccCnt_q;
    logic [CC_W-1:0]  ccCnt_d;
    logic             skipPend_q;
    logic             linkUp_q;
    logic             underrun_q;
    logic             encK_q;
    logic [7:0]       encData_q;

    // Saturating at the last value keeps a skip request alive while a packet holds it off.
    always_comb begin
        ccCnt_d = ccCnt_q;
        if (state_q != ST_SKIP && ccCnt_q != CC_LAST) begin
            ccCnt_d = ccCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_TRAIN;
            wordCnt_q  <= '0;
            ccCnt_q    <= '0;
            skipPend_q <= 1'b0;
            linkUp_q   <= 1'b0;
            underrun_q <= 1'b0;
            encK_q     <= 1'b1;
            encData_q  <= K28_5;
        end else begin
            encData_q  <= K28_5;
            encK_q     <= 1'b1;
            underrun_q <= 1'b0;
            ccCnt_q    <= ccCnt_d;
            if (ccCnt_d == CC_LAST) begin
                skipPend_q <= 1'b1;
            end

            case (state_q)
                ST_TRAIN: begin
                    if (wordCnt_q == TRAIN_LAST) begin
                        state_q   <= ST_IDLE;
                        wordCnt_q <= '0;
                        linkUp_q  <= 1'b1;
                    end else begin
                        wordCnt_q <= wordCnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (train_req) begin
                        state_q   <= ST_TRAIN;
                        wordCnt_q <= '0;
                        linkUp_q  <= 1'b0;
                    end else if (skipPend_q) begin
                        state_q   <= ST_SKIP;
                        wordCnt_q <= '0;
                    end else if (in_valid) begin
                        state_q <= ST_SOP;
                    end
                end
                // Clearing here overrides the sticky set above, which re-fires while held.
                ST_SKIP: begin
                    encData_q <= K28_0;
                    if (wordCnt_q == SKIP_LAST) begin
                        state_q    <= ST_IDLE;
                        wordCnt_q  <= '0;
                        ccCnt_q    <= '0;
                        skipPend_q <= 1'b0;
                    end else begin
                        wordCnt_q <= wordCnt_q + 1'b1;
                    end
                end
                ST_SOP: begin
                    encData_q <= K27_7;
                    state_q   <= ST_DATA;
                end
                ST_DATA: begin
                    if (in_valid) begin
                        encData_q <= in_data;
                        encK_q    <= 1'b0;
                        if (in_last) begin
                            state_q <= ST_EOP;
                        end
                    end else begin
                        underrun_q <= 1'b1;
                    end
                end
                ST_EOP: begin
                    encData_q <= K29_7;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_TRAIN;
                    wordCnt_q <= '0;
                    linkUp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_DATA);
    assign enc_data = encData_q;
    assign enc_k    = encK_q;
    assign link_up  = linkUp_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_enc_tx_sched.sv
// Randomised bench for enc_tx_sched: a remaining-count reference model checked every
// cycle, plus literal expectations for training, skips, framing and async reset.
module tb_enc_tx_sched;

    localparam int TRAIN_LEN   = 16;
    localparam int CC_INTERVAL = 8;
    localparam int SKIP_LEN    = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       train_req = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       link_up;
    logic       underrun;

    int checks = 0;
    int failures = 0;

    enc_tx_sched #(
        .TRAIN_LEN  (TRAIN_LEN),
        .CC_INTERVAL(CC_INTERVAL),
        .SKIP_LEN   (SKIP_LEN)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .train_req(train_req),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .enc_data (enc_data),
        .enc_k    (enc_k),
        .link_up  (link_up),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Reference model: tracks how many training/skip words remain and where in a packet we are.
    int         mTrainLeft;
    int         mSkipLeft;
    int         mCcWords;
    bit         mPend;
    bit         mSopNext;
    bit         mInPkt;
    bit         mEopNext;
    bit         mCount;
    bit         mActive = 1'b0;
    logic [7:0] mData;
    logic       mK;
    logic       mLink;
    logic       mUnder;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mTrainLeft = TRAIN_LEN;
            mSkipLeft  = 0;
            mCcWords   = 0;
            mPend      = 1'b0;
            mSopNext   = 1'b0;
            mInPkt     = 1'b0;
            mEopNext   = 1'b0;
            mData      = 8'hBC;
            mK         = 1'b1;
            mLink      = 1'b0;
            mUnder     = 1'b0;
        end else begin
            mData  = 8'hBC;
            mK     = 1'b1;
            mUnder = 1'b0;
            mCount = (mSkipLeft == 0);
            if (mTrainLeft > 0) begin
                mTrainLeft = mTrainLeft - 1;
                if (mTrainLeft == 0) mLink = 1'b1;
            end else if (mSkipLeft > 0) begin
                mData     = 8'h1C;
                mSkipLeft = mSkipLeft - 1;
                if (mSkipLeft == 0) begin
                    mPend    = 1'b0;
                    mCcWords = 0;
                end
            end else if (mSopNext) begin
                mData    = 8'hFB;
                mSopNext = 1'b0;
                mInPkt   = 1'b1;
            end else if (mInPkt) begin
                if (in_valid) begin
                    mData = in_data;
                    mK    = 1'b0;
                    if (in_last) begin
                        mInPkt   = 1'b0;
                        mEopNext = 1'b1;
                    end
                end else begin
                    mUnder = 1'b1;
                end
            end else if (mEopNext) begin
                mData    = 8'hFD;
                mEopNext = 1'b0;
            end else if (train_req) begin
                mTrainLeft = TRAIN_LEN;
                mLink      = 1'b0;
            end else if (mPend) begin
                mSkipLeft = SKIP_LEN;
            end else if (in_valid) begin
                mSopNext = 1'b1;
            end
            if (mCount) begin
                if (mCcWords < CC_INTERVAL - 1) mCcWords = mCcWords + 1;
                if (mCcWords == CC_INTERVAL - 1) mPend = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n && mActive) begin
            checks++;
            if ({enc_k, enc_data, link_up, underrun, in_ready} !== {mK, mData, mLink, mUnder, mInPkt}) begin
                failures++;
                $display("[TB] FAIL cycle_compare t=%0t got k=%b d=%h link=%b und=%b rdy=%b want k=%b d=%h link=%b und=%b rdy=%b",
                         $time, enc_k, enc_data, link_up, underrun, in_ready, mK, mData, mLink, mUnder, mInPkt);
            end
        end
    end

    // Output log, one entry per edge: {in_ready, underrun, enc_k, enc_data}.
    logic [10:0] outLog[$];

    always @(posedge clk) begin
        #1;
        outLog.push_back({in_ready, underrun, enc_k, enc_data});
    end

    function automatic logic [8:0] wordAt(input int i);
        logic [10:0] w;
        w = outLog[i];
        return w[8:0];
    endfunction

    function automatic int countBit(input int from, input int bitIdx);
        logic [10:0] w;
        int n = 0;
        for (int i = from; i < outLog.size(); i++) begin
            w = outLog[i];
            if (w[bitIdx]) n++;
        end
        return n;
    endfunction

    function automatic int findWord(input int from, input logic [8:0] target);
        for (int i = from; i < outLog.size(); i++) begin
            if (wordAt(i) == target) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte and hold it until accepted; called and returns on a falling edge.
    task automatic applyStimulus(input logic [7:0] d, input logic last);
        int budget = 200;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout byte=%h got=no_ready want=ready", d);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitLinkUp(output int n);
        n = 0;
        while (!link_up && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic checkSequence(input string name, input int from, input logic [8:0] exp[]);
        int f;
        f = findWord(from, 9'h1FB);
        if (f < 0 || f + exp.size() > outLog.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_sop got=missing want=present", name);
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checkOutput($sformatf("%s_w%0d", name, i), 32'(wordAt(f + i)), 32'(exp[i]));
            end
        end
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int startIdx;
        int s1;
        int s2;
        int budget;
        logic [8:0] prevW;
        logic [8:0] curW;
        logic [8:0] seqA[];
        logic [8:0] seqB[];
        logic [8:0] seqC[];

        // Async reset asserted between edges must take effect before any clock.
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset_data", 32'(enc_data), 32'hBC);
        checkOutput("reset_k", 32'(enc_k), 32'h1);
        checkOutput("reset_link", 32'(link_up), 32'h0);
        checkOutput("reset_ready", 32'(in_ready), 32'h0);
        checkOutput("reset_underrun", 32'(underrun), 32'h0);
        idleCycles(2);
        reset_n = 1'b1;
        mActive = 1'b1;

        waitLinkUp(n);
        checkOutput("train_len", 32'(n), 32'(TRAIN_LEN));

        // Idle run: skip sequences every CC_INTERVAL + SKIP_LEN words.
        startIdx = outLog.size();
        idleCycles(40);
        s1 = -1;
        s2 = -1;
        for (int i = startIdx + 1; i < outLog.size() - 2; i++) begin
            if (wordAt(i) == 9'h11C && wordAt(i - 1) != 9'h11C) begin
                if (s1 < 0) s1 = i;
                else if (s2 < 0) s2 = i;
            end
        end
        if (s1 < 0 || s2 < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL cc_skip_found got=missing want=two_skips");
        end else begin
            checkOutput("cc_period", 32'(s2 - s1), 32'(CC_INTERVAL + SKIP_LEN));
            checkOutput("skip_word2", 32'(wordAt(s1 + 1)), 32'h11C);
            checkOutput("skip_end", 32'(wordAt(s1 + 2)), 32'h1BC);
        end

        // Four-byte packet, valid held high.
        startIdx = outLog.size();
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        idleCycles(3);
        seqA = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD};
        checkSequence("pkt4", startIdx, seqA);
        checkOutput("pkt4_ready_cycles", 32'(countBit(startIdx, 10)), 32'd4);
        checkOutput("pkt4_underruns", 32'(countBit(startIdx, 9)), 32'd0);

        // Same packet with a two-cycle valid gap after 0x22.
        startIdx = outLog.size();
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        idleCycles(2);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        idleCycles(3);
        seqB = '{9'h1FB, 9'h011, 9'h022, 9'h1BC, 9'h1BC, 9'h033, 9'h044, 9'h1FD};
        checkSequence("gap", startIdx, seqB);
        checkOutput("gap_underruns", 32'(countBit(startIdx, 9)), 32'd2);
        checkOutput("gap_ready_cycles", 32'(countBit(startIdx, 10)), 32'd6);

        // A request raised just as a skip becomes pending waits behind both skip words.
        prevW = 9'h000;
        curW  = 9'h000;
        budget = 0;
        while (!(prevW == 9'h11C && curW == 9'h11C) && budget < 100) begin
            @(negedge clk);
            prevW = curW;
            curW  = {enc_k, enc_data};
            budget++;
        end
        checkOutput("skip_seen", 32'(budget < 100), 32'h1);
        idleCycles(CC_INTERVAL - 1);
        startIdx = outLog.size();
        applyStimulus(8'h5A, 1'b1);
        idleCycles(2);
        seqC = '{9'h1BC, 9'h11C, 9'h11C, 9'h1BC, 9'h1FB, 9'h05A, 9'h1FD};
        if (startIdx + seqC.size() > outLog.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL pend_seq got=short_log want=%0d_words", seqC.size());
        end else begin
            for (int i = 0; i < seqC.size(); i++) begin
                checkOutput($sformatf("pend_w%0d", i), 32'(wordAt(startIdx + i)), 32'(seqC[i]));
            end
        end

        // Retrain requested mid-packet: packet finishes, then a full burst.
        applyStimulus(8'h11, 1'b0);
        train_req = 1'b1;
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        budget = 0;
        while (link_up && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        train_req = 1'b0;
        checkOutput("retrain_link_fell", 32'(link_up), 32'h0);
        checkOutput("retrain_eop", 32'(wordAt(outLog.size() - 2)), 32'h1FD);
        waitLinkUp(n);
        checkOutput("retrain_len", 32'(n), 32'(TRAIN_LEN));

        // Random packets, gaps and retrain pulses, checked by the model every cycle.
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) begin
                train_req = 1'b1;
                @(negedge clk);
                train_req = 1'b0;
            end
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
                applyStimulus(8'($urandom_range(0, 255)), (b == len - 1));
            end
            idleCycles($urandom_range(0, 12));
        end
        idleCycles(5);

        // Reset mid-packet, asynchronously between edges.
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b0;
        budget = 0;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("rst_pkt_entered", 32'(in_ready), 32'h1);
        idleCycles(2);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_data", 32'(enc_data), 32'hBC);
        checkOutput("midrst_k", 32'(enc_k), 32'h1);
        checkOutput("midrst_link", 32'(link_up), 32'h0);
        checkOutput("midrst_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        idleCycles(2);
        reset_n = 1'b1;
        waitLinkUp(n);
        checkOutput("midrst_train_len", 32'(n), 32'(TRAIN_LEN));
        idleCycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enc_tx_sched.md
# enc_tx_sched

Transmit-side scheduler that drives the 8B/10B encoder front end with one 9-bit character (K flag + 8 bits HGFEDCBA) per clock. After reset it sends a comma training burst, then frames byte packets from an upstream valid/ready source with start and end delimiters. Between packets it fills the link with idle commas and inserts clock-compensation skip sequences at a fixed interval. The encoder consumes its output every cycle; running disparity remains the encoder's responsibility.

## Interface
- TRAIN_LEN, 16: number of K28.5 words sent in the training burst (≥1).
- CC_INTERVAL, 256: output words between clock-compensation requests (≥4).
- SKIP_LEN, 2: K28.0 words per skip sequence (≥1).
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- train_req  in  1  level; request retraining, honoured only in IDLE.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_last  in  1  marks final byte of packet; qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid & in_ready at rising edge.
- enc_data  out  8  character to encoder, HGFEDCBA.
- enc_k  out  1  1 = control character.
- link_up  out  1  high after the training burst completes, low during TRAIN.
- underrun  out  1  one-cycle pulse: DATA state cycle with no byte available.

## Operation
- Characters: IDLE/TRAIN/filler = K28.5 (0xBC, k=1); SOP = K27.7 (0xFB, k=1); EOP = K29.7 (0xFD, k=1); SKIP = K28.0 (0x1C, k=1); payload = in_data, k=0.
- States: TRAIN, IDLE, SKIP, SOP, DATA, EOP.
- TRAIN: emit K28.5; word counter runs 0..TRAIN_LEN-1; after the last word, go to IDLE and set link_up.
- IDLE, priority order:
  - train_req → TRAIN, counter cleared, link_up cleared.
  - Else skip_pend → SKIP.
  - Else in_valid → SOP.
  - Else stay in IDLE.
  - IDLE emits K28.5 in every case.
- SKIP: emit K28.0 for SKIP_LEN cycles, clear skip_pend and the CC counter, then go to IDLE.
- SOP: emit 0xFB for one cycle, then go to DATA; the byte waiting in in_valid is not consumed in SOP.
- DATA:
  - in_ready = 1.
  - Transfer → emit in_data with k=0.
  - No transfer → emit K28.5 filler, pulse underrun, stay in DATA.
  - Transfer with in_last → EOP.
- EOP: emit 0xFD for one cycle, then go to IDLE.
- in_ready is a decode of the state register only: 1 exactly when state = DATA. It has no combinational path from in_valid.
- CC counter:
  - Width clog2(CC_INTERVAL); increments on every output word in all states except SKIP.
  - Reaching CC_INTERVAL-1 sets skip_pend (sticky) and holds the counter there.
  - Skips are inserted only from IDLE, never inside a packet; a pending skip delays the next SOP.
- train_req while a packet is in flight has no effect until the FSM reaches IDLE. The packet is always completed with EOP.

## Timing
- Outputs enc_data, enc_k, link_up and underrun are registered.
- The character chosen in a cycle's state appears on the outputs after the next rising edge. A byte accepted at edge n is on enc_data from edge n until edge n+1 (latency 1).
- Reset (asynchronous assert; deassert sampled on clk):
  - state = TRAIN, counters = 0, skip_pend = 0.
  - enc_data = 0xBC, enc_k = 1, link_up = 0, underrun = 0, in_ready = 0.
- Reset mid-packet abandons the packet: no EOP is sent, and training restarts on the first edge after deassert.
- First non-training word: enc_data leaves K28.5 no earlier than TRAIN_LEN+1 edges after reset release.
- Packet of N bytes with in_valid held high, starting from IDLE: SOP, N data words, EOP on consecutive cycles, i.e. N+2 cycles with no gaps.
- Single-byte packet (in_last on the first byte): SOP, D, EOP.
- Simultaneous train_req and skip_pend in IDLE: TRAIN wins; skip_pend stays set and is serviced after training.

## Test plan
- Reset release, train_req = 0, in_valid = 0 → enc_data/enc_k = 0xBC/1 for 16 words, link_up rises after the 16th, and IDLE continues to output 0xBC.
- After link_up, a 4-byte packet 0x11,0x22,0x33,0x44 (last on 0x44) with in_valid held high → output 0xFB(k1),11,22,33,44(k0),0xFD(k1); in_ready high for exactly 4 cycles; no underrun.
- Same packet with in_valid dropped for 2 cycles after 0x22 → 0xFB,11,22,BC,BC,33,44,FD; two underrun pulses.
- Run idle with CC_INTERVAL = 8 → 0x1C,0x1C (k1) appears every 8+2 words. A packet requested while skip_pend is set starts SOP only after both 0x1C words.
- Assert train_req during DATA → the packet completes with 0xFD, then link_up falls and 16 × 0xBC follow before link_up rises again.
- Assert reset_n = 0 mid-packet, asynchronously between edges → outputs go to 0xBC/1, link_up = 0 and in_ready = 0 immediately, without waiting for a clock edge.
